// File: rtl/bus_sched_pkg.sv
// Shared definitions for the round-robin bus scheduler: FSM state encoding,
// destination ID width, default broadcast ID and the ID-to-mask helper.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    ROUTE = 2'd2,
    PUSH  = 2'd3
  } state_t;

  localparam int ID_W      = 8;
  localparam int MAX_DRVRS = 16;

  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  // One-hot mask for a device index. Callers truncate it to the bus width.
  function automatic logic [MAX_DRVRS-1:0] id_to_mask(input logic [3:0] id);
    logic [MAX_DRVRS-1:0] m;
    m     = '0;
    m[id] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/bus_rr_sched_rr_pick.sv
// Combinational round-robin priority selector. The search starts at the
// device just after the previous winner and wraps around modulo drvrs, so
// the most recently served device has the lowest priority.
module rr_pick #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0] req,
  input  logic [3:0]       last_grant,
  output logic [3:0]       winner,
  output logic             any
);

  // Walk the rotated request vector and keep the first hit.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    any    = 1'b0;
    for (int k = 1; k <= drvrs; k++) begin
      idx = (int'(last_grant) + k) % drvrs;
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = 4'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: grants one device FIFO at a time, pops its head
// packet, decodes the destination ID in the header and pushes the packet to
// the addressed device (or to every other device for the broadcast ID).
// Optional build macro: BUS_BCAST_EN enables broadcast delivery; without it
// the broadcast ID is treated as invalid and the packet is dropped.
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BCAST_ID
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [3:0]               grant_id,
  output logic                     busy,
  output logic [15:0]              drop_cnt
);

  state_t             state;
  logic [3:0]         last_grant;
  logic [pckg_sz-1:0] data_q;

  logic [3:0]         pick_winner;
  logic               pick_any;

  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    route_id;
  logic [drvrs-1:0]   route_mask;
  logic               route_drop;

  rr_pick #(
    .drvrs(drvrs)
  ) u_pick (
    .req       (pndng),
    .last_grant(last_grant),
    .winner    (pick_winner),
    .any       (pick_any)
  );

  // Select the head-of-FIFO word belonging to the granted device.
  always_comb begin
    head = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (grant_id == 4'(i)) begin
        head = D_pop[i*pckg_sz +: pckg_sz];
      end
    end
  end

  // Decode the captured header into a push mask or a drop decision.
  always_comb begin
    route_id   = data_q[pckg_sz-1 -: ID_W];
    route_mask = '0;
    route_drop = 1'b0;
    if ((32'(route_id) < drvrs) && (route_id != {4'b0, grant_id})) begin
      route_mask = drvrs'(id_to_mask(route_id[3:0]));
`ifdef BUS_BCAST_EN
    end else if (route_id == broadcast) begin
      route_mask = ~drvrs'(id_to_mask(grant_id));
`endif
    end else begin
      route_drop = 1'b1;
    end
  end

  // Main scheduler FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      drop_cnt   <= '0;
      last_grant <= 4'(drvrs - 1);
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          pop  <= '0;
          push <= '0;
          if (pick_any) begin
            grant_id   <= pick_winner;
            last_grant <= pick_winner;
            pop        <= drvrs'(id_to_mask(pick_winner));
            busy       <= 1'b1;
            state      <= POP;
          end else begin
            busy <= 1'b0;
          end
        end
        POP: begin
          pop    <= '0;
          data_q <= head;
          state  <= ROUTE;
        end
        ROUTE: begin
          push <= route_mask;
          if (route_mask != '0) begin
            D_push <= data_q;
          end
          if (route_drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
          state <= PUSH;
        end
        PUSH: begin
          push  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          pop   <= '0;
          push  <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed testbench for bus_rr_sched with drvrs=4, pckg_sz=16.
// Expected broadcast behaviour follows the BUS_BCAST_EN build macro.
module tb_bus_rr_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  pndng;
  logic [15:0] heads [4];
  logic [63:0] D_pop;
  logic [3:0]  pop;
  logic [3:0]  push;
  logic [15:0] D_push;
  logic [3:0]  grant_id;
  logic        busy;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  assign D_pop = {heads[3], heads[2], heads[1], heads[0]};

  bus_rr_sched #(
    .drvrs  (4),
    .pckg_sz(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .push    (push),
    .D_push  (D_push),
    .grant_id(grant_id),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] req);
    reset = rst;
    pndng = req;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full 4-cycle transfer starting with the DUT in IDLE.
  task automatic runPacket(input string tag, input logic [3:0] req,
                           input logic [3:0] exp_grant, input logic [3:0] exp_pop,
                           input logic [3:0] exp_push, input logic [15:0] exp_dpush,
                           input logic [15:0] exp_drop);
    applyStimulus(1'b0, req);
    tick();
    checkOutput({tag, ".pop"}, 32'(pop), 32'(exp_pop));
    checkOutput({tag, ".grant"}, 32'(grant_id), 32'(exp_grant));
    checkOutput({tag, ".busy_pop"}, 32'(busy), 32'd1);
    tick();
    checkOutput({tag, ".pop_route"}, 32'(pop), 32'd0);
    checkOutput({tag, ".push_route"}, 32'(push), 32'd0);
    tick();
    checkOutput({tag, ".push"}, 32'(push), 32'(exp_push));
    if (exp_push != 4'd0) checkOutput({tag, ".dpush"}, 32'(D_push), 32'(exp_dpush));
    checkOutput({tag, ".drop"}, 32'(drop_cnt), 32'(exp_drop));
    tick();
    checkOutput({tag, ".push_idle"}, 32'(push), 32'd0);
    checkOutput({tag, ".busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] base_drop;
    applyStimulus(1'b1, 4'b1111);
    heads[0] = 16'h0110;
    heads[1] = 16'h0221;
    heads[2] = 16'h0332;
    heads[3] = 16'h0043;

    // Reset held three cycles with every device pending.
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst.pop", 32'(pop), 32'd0);
      checkOutput("rst.push", 32'(push), 32'd0);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.drop", 32'(drop_cnt), 32'd0);
    end
    checkOutput("rst.dpush", 32'(D_push), 32'd0);

    // Continuous requests: grants 0,1,2,3,0, each pushed to the next device.
    runPacket("rr0", 4'b1111, 4'd0, 4'b0001, 4'b0010, 16'h0110, 16'd0);
    runPacket("rr1", 4'b1111, 4'd1, 4'b0010, 4'b0100, 16'h0221, 16'd0);
    runPacket("rr2", 4'b1111, 4'd2, 4'b0100, 4'b1000, 16'h0332, 16'd0);
    runPacket("rr3", 4'b1111, 4'd3, 4'b1000, 4'b0001, 16'h0043, 16'd0);
    runPacket("rr4", 4'b1111, 4'd0, 4'b0001, 4'b0010, 16'h0110, 16'd0);

    // Single unicast from device 1 to device 2.
    heads[1] = 16'h02AB;
    runPacket("uni", 4'b0010, 4'd1, 4'b0010, 4'b0100, 16'h02AB, 16'd0);

    // Broadcast from device 2.
    heads[2] = 16'hFF55;
`ifdef BUS_BCAST_EN
    base_drop = 16'd0;
    runPacket("bcast", 4'b0100, 4'd2, 4'b0100, 4'b1011, 16'hFF55, base_drop);
`else
    base_drop = 16'd1;
    runPacket("bcast", 4'b0100, 4'd2, 4'b0100, 4'b0000, 16'hFF55, base_drop);
`endif

    // Self-addressed, then out-of-range ID, both from device 3.
    heads[3] = 16'h0311;
    runPacket("self", 4'b1000, 4'd3, 4'b1000, 4'b0000, 16'h0000, base_drop + 16'd1);
    heads[3] = 16'h0722;
    runPacket("range", 4'b1000, 4'd3, 4'b1000, 4'b0000, 16'h0000, base_drop + 16'd2);

    // Reset asserted while a packet from device 0 is in ROUTE.
    heads[0] = 16'h0110;
    applyStimulus(1'b0, 4'b0001);
    tick();
    checkOutput("abort.pop", 32'(pop), 32'b0001);
    tick();
    checkOutput("abort.busy_route", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b0001);
    tick();
    checkOutput("abort.push", 32'(push), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.pop_rst", 32'(pop), 32'd0);
    checkOutput("abort.drop", 32'(drop_cnt), 32'd0);
    runPacket("after", 4'b1111, 4'd0, 4'b0001, 4'b0010, 16'h0110, 16'd0);

    applyStimulus(1'b0, 4'b0000);
    tick();
    checkOutput("end.busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_rr_sched.md
Name: bus_rr_sched

Overview:
- Round-robin scheduler that shares one broadcast-capable bus among `drvrs` device FIFOs.
- Samples each device's pending flag and grants one device at a time.
- Pops that device's head packet, decodes the destination ID in the packet header, and pushes the packet to the addressed device(s).
- Sits between the per-device driver FIFOs and the device-side receive interfaces; it is the arbitration core of the bus generator.

Parameters:
- drvrs, 4, number of devices on the bus (2..16).
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 : pckg_sz-8] are the destination ID (pckg_sz must be ≥ 9).
- broadcast, 8'hFF, destination ID meaning "all devices except sender".

Ports:
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high reset.
- pndng  in  drvrs  per-device "FIFO not empty".
- D_pop  in  drvrs*pckg_sz  head-of-FIFO data; device i occupies bits [i*pckg_sz +: pckg_sz]; valid combinationally while pndng[i]=1.
- pop  out  drvrs  one-hot, 1-cycle pop strobe to the granted FIFO.
- push  out  drvrs  per-device push strobe (multiple bits for broadcast).
- D_push  out  pckg_sz  shared bus data, qualified by push.
- grant_id  out  4  index of the device currently granted.
- busy  out  1  high while the FSM is not IDLE.
- drop_cnt  out  16  count of packets dropped (invalid ID or self-addressed).

Behaviour:
- Reset: state=IDLE, pop=0, push=0, D_push=0, grant_id=0, busy=0, drop_cnt=0, last_grant=drvrs-1 (so device 0 has first priority).
- A reset asserted in any state aborts the transfer on the next edge. A pop already issued is not replayed; that packet is lost.
- FSM states:
  - IDLE: if pndng≠0, select the first i with pndng[i]=1 searching last_grant+1, last_grant+2, … modulo drvrs. Register grant_id=i and last_grant=i, set busy=1, go to POP. Otherwise stay in IDLE.
  - POP: pop[grant_id]=1 for exactly this cycle. Capture D_pop slice grant_id into data_q. Go to ROUTE.
  - ROUTE: decode id=data_q[pckg_sz-1 -: 8].
    - id<drvrs and id≠grant_id: next-cycle push mask = one-hot(id).
    - id==broadcast: mask = all ones except bit grant_id.
    - Otherwise (id ≥ drvrs, or id==grant_id): mask=0 and drop_cnt increments, saturating at 16'hFFFF.
    - Go to PUSH.
  - PUSH: drive push=mask and D_push=data_q for exactly one cycle. Go to IDLE; busy returns to 0 in IDLE.
- Latency: pndng seen in IDLE at cycle N → pop at N+1 → push at N+3 → next arbitration at N+4. Throughput is one packet per 4 cycles.
- pndng is sampled only in IDLE; changes during POP/ROUTE/PUSH are ignored.
- Fairness: with all devices pending continuously, grants follow 0,1,2,…,drvrs-1,0,… Each device waits at most (drvrs-1) packets between grants.
- D_push holds its last value when push=0 (it is not cleared).
- Downstream receive FIFOs must accept the push; there is no backpressure input.

Optional Feature:
- BUS_BCAST_EN defined: ID==broadcast is delivered to all devices except the sender, as described above.
- BUS_BCAST_EN undefined: broadcast is treated as an invalid ID; the packet is dropped and drop_cnt increments.

Decomposition:
- Package bus_sched_pkg holds:
  - state enum {IDLE, POP, ROUTE, PUSH};
  - localparam ID_W=8;
  - the default broadcast ID;
  - a function for one-hot ID-to-mask conversion.
- Sub-module rr_pick: combinational round-robin priority selector (inputs: request vector, last_grant; outputs: winner index, any). This is the only natural split.

Test Plan (drvrs=4, pckg_sz=16):
- Reset held 3 cycles, pndng=4'b1111 → pop=push=0, busy=0, drop_cnt=0 throughout. First grant after release goes to device 0.
- Dev1 pending with head 16'h02AB → pop=4'b0010 one cycle later; push=4'b0100 with D_push=16'h02AB three cycles after sampling.
- All four pending continuously, each head addressed to (i+1)%4 → grant_id sequence 0,1,2,3,0. Each push is one-hot to the next device; one packet per 4 cycles.
- Dev2 head 16'hFF55 with BUS_BCAST_EN defined → push=4'b1011, D_push=16'hFF55. Same stimulus with the macro undefined → push stays 0 and drop_cnt=1.
- Dev3 head 16'h0311 (self), then 16'h0722 (ID 7 out of range) → no push for either; drop_cnt=2.
- Reset asserted during ROUTE of a packet from dev0 → no push occurs, state is IDLE the next cycle, and the next grant goes to device 0.
